// File: rtl/mem_instr_sequencer.sv
// mem_instr_sequencer
//   Fetch/decode/execute engine for the memory-interface instruction ROM.
//   Fetches 56-bit words at PC and decodes four instructions:
//     READ  [7:0]=8'h01   one handshake with the memory read engine
//     SHIFT [7:4]=4'h5    one handshake with the lane shifter (amount = [3:0])
//     WFI   [7:0]=8'h60   waits until wake_i
//     LOOP  [7:0]=8'h70   counts a loop and restarts at PC=0
//   Any other opcode is illegal.
//
//   Build macro MEM_SEQ_STOP_ON_ERR_EN:
//     defined   - an illegal opcode sets err_illegal_o, stops in IDLE and leaves PC
//                 at the faulting address
//     undefined - an illegal opcode sets err_illegal_o, is skipped like a NOP and
//                 execution continues at PC+1
//
// Ports
//   clk_i, rst_ni        clock and asynchronous active-low reset
//   start_i              one-cycle pulse that starts a run at PC=0; ignored while busy
//   rom_address_o/_enable_o, rom_data_i
//                        fetch port; data is valid the cycle after the enable
//   read_req_o/read_ready_i                      read command handshake
//   shift_valid_o/shift_ready_i, shift_amount_o, lane_mask_o, lane_sel_o
//                        shift command handshake and its payload
//   wfi_active_o, wake_i wait-for-wake status and release
//   loop_count_o         completed LOOPs (saturating); cleared by each start
//   busy_o               high whenever the FSM is not IDLE
//   err_illegal_o        sticky illegal-opcode flag; cleared only by reset
//
// DATA_WIDTH must equal 8 + NUM_LANES*LANE_BITS.
// Lane i occupies instr[8+LANE_BITS*i +: LANE_BITS]: bit 2 = valid, bits 1:0 = select.

module mem_instr_sequencer #(
    parameter int DATA_WIDTH = 56,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_LANES  = 16,
    parameter int LANE_BITS  = 3,
    parameter int MAX_LOOPS  = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    output logic [ADDR_WIDTH-1:0]  rom_address_o,
    output logic                   rom_enable_o,
    input  logic [DATA_WIDTH-1:0]  rom_data_i,
    output logic                   read_req_o,
    input  logic                   read_ready_i,
    output logic                   shift_valid_o,
    input  logic                   shift_ready_i,
    output logic [3:0]             shift_amount_o,
    output logic [NUM_LANES-1:0]   lane_mask_o,
    output logic [2*NUM_LANES-1:0] lane_sel_o,
    output logic                   wfi_active_o,
    input  logic                   wake_i,
    output logic [15:0]            loop_count_o,
    output logic                   busy_o,
    output logic                   err_illegal_o
);

    localparam int          LaneW    = NUM_LANES * LANE_BITS;
    localparam logic [15:0] MaxLoops = 16'(MAX_LOOPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_RD,
        S_EXEC_SH,
        S_WAIT,
        S_LOOP_UPD
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [3:0]              amt_q, amt_d;
    logic [LaneW-1:0]        lanes_q, lanes_d;
    logic [15:0]             loop_cnt_q, loop_cnt_d;
    logic                    err_q, err_d;

    logic [7:0]              opcode;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic [15:0]             loop_inc;

    assign opcode   = rom_data_i[7:0];
    assign pc_inc   = pc_q + ADDR_WIDTH'(1);
    assign loop_inc = (loop_cnt_q == 16'hFFFF) ? loop_cnt_q : loop_cnt_q + 16'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            amt_q      <= '0;
            lanes_q    <= '0;
            loop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            amt_q      <= amt_d;
            lanes_q    <= lanes_d;
            loop_cnt_q <= loop_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        amt_d         = amt_q;
        lanes_d       = lanes_q;
        loop_cnt_d    = loop_cnt_q;
        err_d         = err_q;
        rom_enable_o  = 1'b0;
        read_req_o    = 1'b0;
        shift_valid_o = 1'b0;
        wfi_active_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pc_d       = '0;
                    loop_cnt_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                rom_enable_o = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                // Payload is captured for every word so the shift outputs are
                // register-driven and cannot move while the handshake is pending.
                amt_d   = rom_data_i[3:0];
                lanes_d = rom_data_i[8 +: LaneW];
                if (opcode == 8'h01) begin
                    state_d = S_EXEC_RD;
                end else if (opcode[7:4] == 4'h5) begin
                    state_d = S_EXEC_SH;
                end else if (opcode == 8'h60) begin
                    state_d = S_WAIT;
                end else if (opcode == 8'h70) begin
                    state_d = S_LOOP_UPD;
                end else begin
                    err_d = 1'b1;
`ifdef MEM_SEQ_STOP_ON_ERR_EN
                    state_d = S_IDLE;
`else
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC_RD: begin
                read_req_o = 1'b1;
                if (read_ready_i) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_SH: begin
                shift_valid_o = 1'b1;
                if (shift_ready_i) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_WAIT: begin
                wfi_active_o = 1'b1;
                if (wake_i) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_LOOP_UPD: begin
                loop_cnt_d = loop_inc;
                pc_d       = '0;
                if ((MAX_LOOPS != 0) && (loop_inc == MaxLoops)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Shift payload is forced to zero outside EXEC_SH so downstream logic never
    // sees stale lane data.
    always_comb begin
        shift_amount_o = '0;
        lane_mask_o    = '0;
        lane_sel_o     = '0;
        if (state_q == S_EXEC_SH) begin
            shift_amount_o = amt_q;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_mask_o[i]       = lanes_q[LANE_BITS*i + 2];
                lane_sel_o[2*i +: 2] = lanes_q[LANE_BITS*i +: 2];
            end
        end
    end

    assign rom_address_o = pc_q;
    assign loop_count_o  = loop_cnt_q;
    assign busy_o        = (state_q != S_IDLE);
    assign err_illegal_o = err_q;

endmodule

// File: tb/tb_mem_instr_sequencer.sv
module tb_mem_instr_sequencer;

    localparam logic [55:0] W_READ = 56'h01;
    localparam logic [55:0] W_WFI  = 56'h60;
    localparam logic [55:0] W_LOOP = 56'h70;
    localparam int EV_FETCH = 0;
    localparam int EV_READ  = 1;
    localparam int EV_SHIFT = 2;

    typedef struct {
        int          kind;
        logic [5:0]  addr;
        logic [3:0]  amt;
        logic [15:0] mask;
        logic [31:0] sel;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, start2 = 1'b0;
    logic read_ready = 1'b0, shift_ready = 1'b0, wake = 1'b0;
    logic [55:0] rom_data = '0, rom_data2 = '0;
    logic [55:0] rom_mem [64];

    logic [5:0]  rom_addr, rom_addr2;
    logic        rom_en, rom_en2, read_req, read_req2, shift_valid, shift_valid2;
    logic [3:0]  shift_amt, shift_amt2;
    logic [15:0] lane_mask, lane_mask2, loop_count, loop_count2;
    logic [31:0] lane_sel, lane_sel2;
    logic        wfi, wfi2, busy, busy2, err, err2;

    int  checks = 0;
    int  errors = 0;
    ev_t sbq[$];
    bit  sb_on = 1'b0;

    always #5 clk = ~clk;

    // Synchronous ROM models: data appears the cycle after the enable.
    always @(posedge clk) begin
        if (rom_en)  rom_data  <= rom_mem[rom_addr];
        if (rom_en2) rom_data2 <= rom_mem[rom_addr2];
    end

    mem_instr_sequencer #(.MAX_LOOPS(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .rom_address_o(rom_addr), .rom_enable_o(rom_en), .rom_data_i(rom_data),
        .read_req_o(read_req), .read_ready_i(read_ready),
        .shift_valid_o(shift_valid), .shift_ready_i(shift_ready),
        .shift_amount_o(shift_amt), .lane_mask_o(lane_mask), .lane_sel_o(lane_sel),
        .wfi_active_o(wfi), .wake_i(wake), .loop_count_o(loop_count),
        .busy_o(busy), .err_illegal_o(err)
    );

    mem_instr_sequencer #(.MAX_LOOPS(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start2),
        .rom_address_o(rom_addr2), .rom_enable_o(rom_en2), .rom_data_i(rom_data2),
        .read_req_o(read_req2), .read_ready_i(read_ready),
        .shift_valid_o(shift_valid2), .shift_ready_i(shift_ready),
        .shift_amount_o(shift_amt2), .lane_mask_o(lane_mask2), .lane_sel_o(lane_sel2),
        .wfi_active_o(wfi2), .wake_i(wake), .loop_count_o(loop_count2),
        .busy_o(busy2), .err_illegal_o(err2)
    );

    function automatic void push_fetch(input logic [5:0] a);
        ev_t e;
        e.kind = EV_FETCH; e.addr = a; e.amt = '0; e.mask = '0; e.sel = '0;
        sbq.push_back(e);
    endfunction

    function automatic void push_read();
        ev_t e;
        e.kind = EV_READ; e.addr = '0; e.amt = '0; e.mask = '0; e.sel = '0;
        sbq.push_back(e);
    endfunction

    function automatic void push_shift(input logic [55:0] w);
        ev_t e;
        e.kind = EV_SHIFT; e.addr = '0; e.amt = w[3:0]; e.mask = '0; e.sel = '0;
        for (int i = 0; i < 16; i++) begin
            e.mask[i]       = w[8 + 3*i + 2];
            e.sel[2*i +: 2] = w[8 + 3*i +: 2];
        end
        sbq.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sb_on = 1'b0;
        start = 1'b0; start2 = 1'b0; wake = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        sbq.delete();
    endtask

    // Scoreboard consumer: every fetch and every accepted command must match the
    // head of the expected-event queue, in order.
    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (sb_on) begin
                if (rom_en) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL fetch: unexpected fetch of addr %0d", rom_addr);
                    end else begin
                        e = sbq.pop_front();
                        if (e.kind !== EV_FETCH || e.addr !== rom_addr) begin
                            errors++;
                            $display("FAIL fetch: got fetch addr %0d, expected kind %0d addr %0d",
                                     rom_addr, e.kind, e.addr);
                        end
                    end
                end
                if (read_req && read_ready) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL read_cmd: unexpected read accepted at pc %0d", rom_addr);
                    end else begin
                        e = sbq.pop_front();
                        if (e.kind !== EV_READ) begin
                            errors++;
                            $display("FAIL read_cmd: got read at pc %0d, expected event kind %0d",
                                     rom_addr, e.kind);
                        end
                    end
                end
                if (shift_valid) begin
                    checks++;
                    if (sbq.size() == 0 || sbq[0].kind != EV_SHIFT) begin
                        errors++;
                        $display("FAIL shift_cmd: unexpected shift valid, amt %0d mask %h", shift_amt, lane_mask);
                    end else begin
                        if (shift_amt !== sbq[0].amt || lane_mask !== sbq[0].mask || lane_sel !== sbq[0].sel) begin
                            errors++;
                            $display("FAIL shift_cmd: got amt %0d mask %h sel %h, expected amt %0d mask %h sel %h",
                                     shift_amt, lane_mask, lane_sel, sbq[0].amt, sbq[0].mask, sbq[0].sel);
                        end
                        if (shift_ready) e = sbq.pop_front();
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({rom_addr, rom_en, read_req, shift_valid, shift_amt, lane_mask, lane_sel,
             wfi, loop_count, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr %0d en %b rd %b sv %b loop %0d busy %b err %b, expected all 0",
                     rom_addr, rom_en, read_req, shift_valid, loop_count, busy, err);
        end
        checks++;
        if ({rom_addr2, rom_en2, read_req2, shift_valid2, shift_amt2, lane_mask2, lane_sel2,
             wfi2, loop_count2, busy2, err2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs2: got busy %b loop %0d, expected all 0", busy2, loop_count2);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_wfi_loop();
        rom_mem[0] = W_READ; rom_mem[1] = W_WFI; rom_mem[2] = W_LOOP;
        read_ready = 1'b1; wake = 1'b0;
        push_fetch(0); push_read(); push_fetch(1); push_fetch(2);
        push_fetch(0); push_read(); push_fetch(1);
        sb_on = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 6'd0) begin
            errors++;
            $display("FAIL start_latency: got en %b addr %0d, expected en 1 addr 0", rom_en, rom_addr);
        end
        step();
        checks++;
        if (read_req !== 1'b0) begin
            errors++; $display("FAIL read_early: got read_req %b in decode, expected 0", read_req);
        end
        step();
        checks++;
        if (read_req !== 1'b1) begin
            errors++; $display("FAIL read_at_start_plus3: got read_req %b, expected 1", read_req);
        end
        step();
        checks++;
        if (read_req !== 1'b0 || rom_addr !== 6'd1) begin
            errors++; $display("FAIL read_drop: got read_req %b addr %0d, expected 0 and 1", read_req, rom_addr);
        end
        step(); step();
        checks++;
        if (wfi !== 1'b1) begin
            errors++; $display("FAIL wfi_enter: got wfi_active %b, expected 1", wfi);
        end
        repeat (3) step();
        checks++;
        if (wfi !== 1'b1 || loop_count !== 16'd0 || rom_en !== 1'b0) begin
            errors++; $display("FAIL wfi_hold: got wfi %b loop %0d en %b, expected 1 0 0", wfi, loop_count, rom_en);
        end
        wake = 1'b1; step(); wake = 1'b0;
        checks++;
        if (wfi !== 1'b0 || rom_addr !== 6'd2) begin
            errors++; $display("FAIL wfi_release: got wfi %b addr %0d, expected 0 and 2", wfi, rom_addr);
        end
        step(); step(); step();
        checks++;
        if (loop_count !== 16'd1 || rom_en !== 1'b1 || rom_addr !== 6'd0) begin
            errors++;
            $display("FAIL loop_update: got count %0d en %b addr %0d, expected 1 1 0", loop_count, rom_en, rom_addr);
        end
        for (int n = 0; n < 20 && sbq.size() != 0; n++) step();
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL loop_events: %0d expected events not seen, expected 0 left", sbq.size());
        end
        do_reset();
    endtask

    task automatic test_shift();
        rom_mem[0] = 56'h00_0000_0001_205F;
        rom_mem[1] = 56'h5A_C3E1_9B27_0F53;
        rom_mem[2] = W_WFI;
        shift_ready = 1'b0;
        push_fetch(0); push_shift(rom_mem[0]); push_fetch(1); push_shift(rom_mem[1]); push_fetch(2);
        sb_on = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        checks++;
        if (shift_valid !== 1'b1 || shift_amt !== 4'd15 || lane_mask !== 16'h0006 || lane_sel !== 32'h0) begin
            errors++;
            $display("FAIL shift_decode: got valid %b amt %0d mask %h sel %h, expected 1 15 0006 00000000",
                     shift_valid, shift_amt, lane_mask, lane_sel);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (shift_valid !== 1'b1 || rom_en !== 1'b0 || rom_addr !== 6'd0 || shift_amt !== 4'd15) begin
                errors++;
                $display("FAIL shift_hold: cycle %0d got valid %b en %b addr %0d amt %0d, expected 1 0 0 15",
                         i, shift_valid, rom_en, rom_addr, shift_amt);
            end
        end
        shift_ready = 1'b1;
        step();
        checks++;
        if (shift_valid !== 1'b0 || rom_addr !== 6'd1 || rom_en !== 1'b1) begin
            errors++;
            $display("FAIL shift_release: got valid %b addr %0d en %b, expected 0 1 1", shift_valid, rom_addr, rom_en);
        end
        for (int n = 0; n < 20 && sbq.size() != 0; n++) step();
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL shift_events: %0d expected events not seen, expected 0 left", sbq.size());
        end
        step(); step();
        checks++;
        if (wfi !== 1'b1 || rom_addr !== 6'd2) begin
            errors++; $display("FAIL shift_to_wfi: got wfi %b addr %0d, expected 1 2", wfi, rom_addr);
        end
        shift_ready = 1'b0;
        do_reset();
    endtask

    task automatic test_max_loops();
        int busy_cycles;
        int fetches;
        rom_mem[0] = W_READ; rom_mem[1] = W_LOOP;
        read_ready = 1'b1;
        for (int run = 0; run < 2; run++) begin
            busy_cycles = 0; fetches = 0;
            start2 = 1'b1; step(); start2 = 1'b0;
            checks++;
            if (loop_count2 !== 16'd0 || busy2 !== 1'b1) begin
                errors++;
                $display("FAIL start_clears_count: run %0d got count %0d busy %b, expected 0 1", run, loop_count2, busy2);
            end
            for (int n = 0; n < 40 && busy2; n++) begin
                busy_cycles++;
                if (rom_en2) fetches++;
                step();
            end
            checks++;
            if (busy_cycles != 12 || loop_count2 !== 16'd2 || busy2 !== 1'b0) begin
                errors++;
                $display("FAIL max_loops_stop: run %0d got busy cycles %0d count %0d busy %b, expected 12 2 0",
                         run, busy_cycles, loop_count2, busy2);
            end
            repeat (5) begin
                if (rom_en2) fetches++;
                step();
            end
            checks++;
            if (fetches != 4 || busy2 !== 1'b0) begin
                errors++;
                $display("FAIL max_loops_quiet: run %0d got %0d fetches busy %b, expected 4 0", run, fetches, busy2);
            end
        end
        checks++;
        if ({read_req2, shift_valid2, shift_amt2, lane_mask2, lane_sel2, wfi2, err2} !== '0) begin
            errors++;
            $display("FAIL max_loops_idle: got rd %b sv %b wfi %b err %b, expected all 0",
                     read_req2, shift_valid2, wfi2, err2);
        end
        do_reset();
    endtask

    task automatic test_illegal();
        int n;
        rom_mem[0] = W_READ; rom_mem[1] = W_READ; rom_mem[2] = W_READ;
        rom_mem[3] = 56'h30; rom_mem[4] = W_WFI; rom_mem[5] = W_WFI;
        read_ready = 1'b1;
        push_fetch(0); push_read(); push_fetch(1); push_read();
        push_fetch(2); push_read(); push_fetch(3);
`ifndef MEM_SEQ_STOP_ON_ERR_EN
        push_fetch(4);
`endif
        sb_on = 1'b1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clear: got err %b before illegal word, expected 0", err);
        end
        start = 1'b1; step(); start = 1'b0;
        n = 1;
        while (!(rom_en && rom_addr == 6'd3) && n < 30) begin
            step(); n++;
        end
        checks++;
        if (n != 10) begin
            errors++; $display("FAIL b2b_latency: got fetch of addr 3 at cycle %0d, expected 10", n);
        end
        step(); step();
`ifdef MEM_SEQ_STOP_ON_ERR_EN
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || rom_addr !== 6'd3) begin
            errors++;
            $display("FAIL illegal_stop: got err %b busy %b pc %0d, expected 1 0 3", err, busy, rom_addr);
        end
        repeat (3) step();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL illegal_sticky: got err %b busy %b pending %0d, expected 1 0 0", err, busy, sbq.size());
        end
`else
        checks++;
        if (err !== 1'b1 || rom_en !== 1'b1 || rom_addr !== 6'd4) begin
            errors++;
            $display("FAIL illegal_skip: got err %b en %b addr %0d, expected 1 1 4", err, rom_en, rom_addr);
        end
        step(); step();
        push_fetch(5);
        wake = 1'b1; step(); wake = 1'b0;
        checks++;
        if (err !== 1'b1 || rom_addr !== 6'd5) begin
            errors++; $display("FAIL illegal_sticky: got err %b addr %0d, expected 1 5", err, rom_addr);
        end
        step();
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL illegal_events: %0d expected events not seen, expected 0 left", sbq.size());
        end
`endif
        do_reset();
    endtask

    task automatic test_reset_mid_read();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL reset_clears_err: got err %b after reset, expected 0", err);
        end
        rom_mem[0] = W_READ; rom_mem[1] = W_WFI;
        read_ready = 1'b0;
        push_fetch(0);
        sb_on = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        checks++;
        if (read_req !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL read_stall: got read_req %b busy %b, expected 1 1", read_req, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (read_req !== 1'b0 || busy !== 1'b0 || rom_addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_abort: got read_req %b busy %b pc %0d, expected 0 0 0", read_req, busy, rom_addr);
        end
        step();
        rst_n = 1'b1;
        read_ready = 1'b1;
        step();
        push_fetch(0); push_read(); push_fetch(1);
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 6'd0) begin
            errors++; $display("FAIL restart_fetch: got en %b addr %0d, expected 1 0", rom_en, rom_addr);
        end
        for (int n = 0; n < 20 && sbq.size() != 0; n++) step();
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL restart_events: %0d expected events not seen, expected 0 left", sbq.size());
        end
        do_reset();
    endtask

    task automatic test_pc_wrap();
        for (int i = 0; i < 64; i++) rom_mem[i] = W_READ;
        read_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            push_fetch(6'(i)); push_read();
        end
        push_fetch(0);
        sb_on = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int n = 0; n < 300 && sbq.size() != 0; n++) step();
        checks++;
        if (sbq.size() != 0 || rom_addr !== 6'd0 || busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap: got %0d pending, pc %0d busy %b err %b, expected 0 0 1 0",
                     sbq.size(), rom_addr, busy, err);
        end
        do_reset();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = W_WFI;
        fork
            monitor();
        join_none
        test_reset();
        test_read_wfi_loop();
        test_shift();
        test_max_loops();
        test_illegal();
        test_reset_mid_read();
        test_pc_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
